// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU execution sequencer: state encoding,
// default free-run divider and the divider-counter width helper.
package cpu_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_BRK  = 2'd2;

    localparam int RUN_DIV_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_BRK  = ST_BRK
    } run_state_e;

    // A divide-by-1 still needs a one-bit counter to keep the datapath legal.
    function automatic int div_cnt_w(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the datapath/front panel (master) and the
// execution sequencer (slave).
interface cpu_run_ctrl_if #(
    parameter int CNT_W = 32
) ();

    logic             step_btn;
    logic             run_sw;
    logic             halt_req;
    logic [31:0]      pc;
    logic [31:0]      bp_addr;
    logic             bp_valid;
    logic             pc_we;
    logic [1:0]       state;
    logic [CNT_W-1:0] retired;
    logic             brk_hit;

    modport master (
        output step_btn, run_sw, halt_req, pc, bp_addr, bp_valid,
        input  pc_we, state, retired, brk_hit
    );

    modport slave (
        input  step_btn, run_sw, halt_req, pc, bp_addr, bp_valid,
        output pc_we, state, retired, brk_hit
    );

endinterface

// File: rtl/cpu_run_ctrl_rise_detect.sv
// Registered rising-edge detector for an already-debounced level input.
// The rise output is a one-cycle pulse in the cycle after the level is first sampled high.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in_lvl,
    output logic rise
);

    logic lvl_q;
    logic lvl_d;
    logic rise_q;
    logic rise_d;

    // Next-state: track the level and flag a low-to-high transition.
    always_comb begin
        lvl_d  = in_lvl;
        rise_d = in_lvl & ~lvl_q;
    end

    // Level history and registered rise pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution sequencer: single-step, divided free-run and retired count.
// Optional PC breakpoint (BRK state, brk_hit) is built when CPU_BREAKPOINT_EN is defined.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RUN_DIV = RUN_DIV_DEFAULT,
    parameter int CNT_W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    cpu_run_ctrl_if.slave  bus
);

    localparam int               DIV_W    = div_cnt_w(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    run_state_e       state_q;
    run_state_e       state_d;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             pc_we_q;
    logic             pc_we_d;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;
    logic             brk_hit_q;
    logic             brk_hit_d;
    logic             step_rise;
    logic             cnt_last;

    rise_detect u_step_rise (
        .clk    (clk),
        .rst    (rst),
        .in_lvl (bus.step_btn),
        .rise   (step_rise)
    );

    assign cnt_last = (cnt_q == DIV_LAST);

`ifdef CPU_BREAKPOINT_EN
    logic bp_match;
    assign bp_match = bus.bp_valid & (bus.pc == bus.bp_addr);
`endif

    // Next-state, divider, commit pulse and sticky breakpoint flag.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_we_d   = 1'b0;
        brk_hit_d = brk_hit_q;
        retired_d = retired_q + CNT_W'(pc_we_q);

        if (bus.halt_req) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Entering RUN swallows a coincident step.
                    if (bus.run_sw) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else if (step_rise) begin
                        pc_we_d = 1'b1;
                    end else begin
                        pc_we_d = 1'b0;
                    end
                end
                S_RUN: begin
                    if (!bus.run_sw) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_last) begin
`ifdef CPU_BREAKPOINT_EN
                        if (bp_match) begin
                            state_d   = S_BRK;
                            brk_hit_d = 1'b1;
                        end else begin
                            pc_we_d = 1'b1;
                            cnt_d   = '0;
                        end
`else
                        pc_we_d = 1'b1;
                        cnt_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                S_BRK: begin
                    // The step out of BRK commits the breakpointed instruction unconditionally.
                    if (step_rise) begin
                        pc_we_d   = 1'b1;
                        brk_hit_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = bus.run_sw ? S_RUN : S_IDLE;
                    end else if (!bus.run_sw) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_BRK;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, divider, pulse, counter and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pc_we_q   <= 1'b0;
            retired_q <= '0;
            brk_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_we_q   <= pc_we_d;
            retired_q <= retired_d;
            brk_hit_q <= brk_hit_d;
        end
    end

    assign bus.pc_we   = pc_we_q;
    assign bus.state   = state_q;
    assign bus.retired = retired_q;
    assign bus.brk_hit = brk_hit_q;

endmodule
